// File: rtl/bounce_emulator_pkg.sv
// Shared definitions for the bounce emulator: FSM states, LFSR polynomial and default seed.
package bounce_emulator_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned CNT_W  = 8;

  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : LFSR_W'(0));
  endfunction

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads the seed on reset, otherwise steps every cycle.
module lfsr16
  import bounce_emulator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/bounce_emulator.sv
// Turns a clean level command into a pseudo-random bounce burst, holds the new level for a
// settle period, then pulses done. One command in flight at a time.
module bounce_emulator
  import bounce_emulator_pkg::*;
#(
  parameter int unsigned       BOUNCE_BITS   = 3,
  parameter int unsigned       GAP_BITS      = 4,
  parameter int unsigned       MIN_GAP       = 4,
  parameter int unsigned       SETTLE_CYCLES = 1000,
  parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_level,
  output logic             cmd_ready,
  output logic             bounce_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bounce_cnt
);

  localparam int unsigned TOG_W     = BOUNCE_BITS + 1;
  localparam int unsigned GAP_MAX   = MIN_GAP + (32'd1 << GAP_BITS) - 32'd1;
  localparam int unsigned GAP_W_RAW = $clog2(GAP_MAX + 1);
  localparam int unsigned GAP_W     = (GAP_W_RAW > GAP_BITS + 1) ? GAP_W_RAW : GAP_BITS + 1;
  localparam int unsigned SET_W     = $clog2(SETTLE_CYCLES + 1);

  localparam logic [LFSR_W-1:0] K_MASK = LFSR_W'((32'd1 << BOUNCE_BITS) - 32'd1);
  localparam logic [LFSR_W-1:0] G_MASK = LFSR_W'((32'd1 << GAP_BITS) - 32'd1);
  localparam logic [SET_W-1:0]  SETTLE_RELOAD = SET_W'(SETTLE_CYCLES - 32'd1);

  logic [LFSR_W-1:0] lfsr_val;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr_val)
  );

  state_e            state_q,      state_d;
  logic              bounce_out_q, bounce_out_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [TOG_W-1:0]  tog_q,        tog_d;
  logic [GAP_W-1:0]  gap_q,        gap_d;
  logic [SET_W-1:0]  settle_q,     settle_d;
  logic              noop_q,       noop_d;
  logic              done_q,       done_d;
  logic              busy_q,       busy_d;
  logic              ready_q,      ready_d;

  logic              accept;
  logic [LFSR_W-1:0] k_raw;
  logic [LFSR_W-1:0] g_raw;
  logic [TOG_W-1:0]  burst_len;
  logic [GAP_W-1:0]  gap_reload;

  // Burst length 2k+1 and the next inter-toggle gap (stored as G-1) from the current LFSR value.
  always_comb begin
    k_raw      = lfsr_val & K_MASK;
    g_raw      = (lfsr_val >> 8) & G_MASK;
    burst_len  = TOG_W'({k_raw, 1'b1});
    gap_reload = GAP_W'(MIN_GAP - 32'd1 + 32'(g_raw));
  end

  always_comb begin
    state_d      = state_q;
    bounce_out_d = bounce_out_q;
    cnt_d        = cnt_q;
    tog_d        = tog_q;
    gap_d        = gap_q;
    settle_d     = settle_q;
    noop_d       = 1'b0;
    done_d       = noop_q;
    accept       = cmd_valid && ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (cmd_level == bounce_out_q) begin
            noop_d = 1'b1;
          end else begin
            tog_d   = burst_len;
            gap_d   = '0;
            state_d = ST_BOUNCE;
          end
        end
      end

      ST_BOUNCE: begin
        if (gap_q == '0) begin
          bounce_out_d = ~bounce_out_q;
          cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          tog_d        = tog_q - TOG_W'(1);
          gap_d        = gap_reload;
          // Odd burst length means the last toggle lands on the requested level.
          if (tog_q == TOG_W'(1)) begin
            settle_d = SETTLE_RELOAD;
            state_d  = ST_SETTLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      ST_SETTLE: begin
        if (settle_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bounce_out_q <= 1'b0;
      cnt_q        <= '0;
      tog_q        <= '0;
      gap_q        <= '0;
      settle_q     <= '0;
      noop_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      bounce_out_q <= bounce_out_d;
      cnt_q        <= cnt_d;
      tog_q        <= tog_d;
      gap_q        <= gap_d;
      settle_q     <= settle_d;
      noop_q       <= noop_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign bounce_out = bounce_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bounce_cnt = cnt_q;

endmodule

// File: tb/tb_bounce_emulator.sv
// Bench for bounce_emulator: transaction-level reference model, directed steps and random traffic.
module tb_bounce_emulator;

  localparam int unsigned A_BB   = 3;
  localparam int unsigned A_GB   = 4;
  localparam int unsigned A_MIN  = 4;
  localparam int unsigned A_SET  = 25;
  localparam logic [15:0] A_SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_valid, a_level, a_ready, a_out, a_busy, a_done;
  logic [7:0] a_cnt;
  logic       b_valid, b_level, b_ready, b_out, b_busy, b_done;
  logic [7:0] b_cnt;

  bounce_emulator #(
    .BOUNCE_BITS(A_BB), .GAP_BITS(A_GB), .MIN_GAP(A_MIN), .SETTLE_CYCLES(A_SET), .SEED(A_SEED)
  ) dut_a (
    .clk(clk), .reset(rst_n), .cmd_valid(a_valid), .cmd_level(a_level), .cmd_ready(a_ready),
    .bounce_out(a_out), .busy(a_busy), .done(a_done), .bounce_cnt(a_cnt)
  );

  bounce_emulator #(
    .BOUNCE_BITS(0), .GAP_BITS(0), .MIN_GAP(4), .SETTLE_CYCLES(10), .SEED(A_SEED)
  ) dut_b (
    .clk(clk), .reset(rst_n), .cmd_valid(b_valid), .cmd_level(b_level), .cmd_ready(b_ready),
    .bounce_out(b_out), .busy(b_busy), .done(b_done), .bounce_cnt(b_cnt)
  );

  int checks = 0;
  int errors = 0;
  int e      = 0;

  // Reference model state for instance A.
  logic [15:0] m_lfsr;
  logic        m_out, m_busy, m_done, m_level;
  int          m_cnt, m_done_t, m_acc_e;
  int          m_tq[$];
  logic        m_acc_burst, m_burst_end;

  int   dut_tog[$];
  logic prev_out = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic        acc;
    logic [15:0] s;
    int          t, ntog, g;
    m_acc_burst = 1'b0;
    m_burst_end = 1'b0;
    if (!rst_n) begin
      m_lfsr = A_SEED; m_out = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      m_tq.delete(); m_done_t = -1;
    end else begin
      acc    = a_valid && !m_busy;
      m_done = (m_done_t == e);
      if (m_done) begin
        m_burst_end = m_busy;
        m_done_t    = -1;
        m_busy      = 1'b0;
      end
      if (acc) begin
        m_cnt = 0;
        if (a_level == m_out) begin
          m_done_t = e + 1;
        end else begin
          ntog = 2 * (int'(m_lfsr) % (1 << A_BB)) + 1;
          s    = lfsr_next(m_lfsr);
          t    = e + 1;
          for (int i = 0; i < ntog; i++) begin
            m_tq.push_back(t);
            if (i < ntog - 1) begin
              g = A_MIN + ((int'(s) >> 8) % (1 << A_GB));
              for (int j = 0; j < g; j++) s = lfsr_next(s);
              t = t + g;
            end
          end
          m_done_t    = t + A_SET;
          m_busy      = 1'b1;
          m_level     = a_level;
          m_acc_e     = e;
          m_acc_burst = 1'b1;
        end
      end
      if (m_tq.size() > 0 && m_tq[0] == e) begin
        void'(m_tq.pop_front());
        m_out = ~m_out;
        if (m_cnt < 255) m_cnt++;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  // Waveform properties of a finished burst, measured from the DUT's own toggle times.
  task automatic burst_props();
    int n;
    n = dut_tog.size();
    chk("burst_odd_count", n % 2, 1);
    chk("burst_max_count", (n >= 1 && n <= 15), 1);
    chk("burst_cnt_matches", a_cnt, n);
    chk("burst_final_level", a_out, m_level);
    if (n > 0) begin
      chk("first_toggle_latency", dut_tog[0] - m_acc_e, 1);
      chk("settle_length", e - dut_tog[n-1], A_SET);
      for (int i = 1; i < n; i++)
        chk("gap_range", (dut_tog[i] - dut_tog[i-1] >= 4 && dut_tog[i] - dut_tog[i-1] <= 19), 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    model_edge();
    #1;
    chk("a_out", a_out, m_out);
    chk("a_busy", a_busy, m_busy);
    chk("a_ready", a_ready, !m_busy);
    chk("a_done", a_done, m_done);
    chk("a_cnt", a_cnt, m_cnt);
    if (m_acc_burst) dut_tog.delete();
    if (a_out !== prev_out) dut_tog.push_back(e);
    prev_out = a_out;
    if (m_burst_end) burst_props();
  endtask

  task automatic wait_done(input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (a_done === 1'b1) break;
    end
    chk(tag, a_done, 1);
  endtask

  task automatic wait_long_burst();
    for (int i = 0; i < 64 && (int'(m_lfsr) % (1 << A_BB)) == 0; i++) tick();
  endtask

  int n0, seen_done, rep_r;
  int rep1[$], rep2[$];

  initial begin
    rst_n = 1'b0; a_valid = 1'b1; a_level = 1'b1; b_valid = 1'b0; b_level = 1'b0;
    m_done_t = -1; m_busy = 1'b0;

    // Reset held with a pending command: nothing is accepted.
    repeat (3) tick();
    chk("reset_busy", a_busy, 0);
    chk("reset_cnt", a_cnt, 0);
    chk("reset_b_out", b_out, 0);
    rst_n = 1'b1; a_valid = 1'b0;
    tick();

    // No-op: requested level already present.
    a_valid = 1'b1; a_level = 1'b0;
    tick();
    a_valid = 1'b0;
    chk("noop_done_early", a_done, 0);
    tick();
    chk("noop_done", a_done, 1);
    chk("noop_busy", a_busy, 0);
    tick();
    chk("noop_done_clear", a_done, 0);
    chk("noop_out", a_out, 0);

    // Single-toggle instance: toggle one edge after accept, done ten edges later.
    b_valid = 1'b1; b_level = 1'b1;
    tick();
    n0 = e; b_valid = 1'b0;
    chk("b_accept_out", b_out, 0);
    chk("b_accept_busy", b_busy, 1);
    chk("b_accept_ready", b_ready, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("b_out", b_out, 1);
      chk("b_done", b_done, (e == n0 + 11));
      chk("b_busy", b_busy, (e < n0 + 11));
      chk("b_ready", b_ready, (e >= n0 + 11));
      chk("b_cnt", b_cnt, 1);
    end

    // Commands arriving during a burst are dropped.
    wait_long_burst();
    a_valid = 1'b1; a_level = 1'b1;
    tick();
    a_level = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("busy_drop_ready", a_ready, 0);
    end
    a_valid = 1'b0;
    wait_done(600, "busy_drop_done_timeout");
    chk("busy_drop_final", a_out, 1);
    tick();

    // Reset after the third toggle aborts the burst with no done pulse.
    wait_long_burst();
    a_valid = 1'b1; a_level = 1'b0;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 200 && dut_tog.size() < 3; i++) tick();
    chk("three_toggles_seen", (dut_tog.size() >= 3), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_out", a_out, 0);
    chk("midreset_busy", a_busy, 0);
    chk("midreset_ready", a_ready, 1);
    seen_done = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (a_done === 1'b1) seen_done++;
    end
    chk("midreset_no_done", seen_done, 0);

    // Same seed and same command timing give the same waveform.
    for (int pass = 0; pass < 2; pass++) begin
      rst_n = 1'b0;
      tick();
      rep_r = e; rst_n = 1'b1;
      repeat (5) tick();
      a_valid = 1'b1; a_level = 1'b1;
      tick();
      a_valid = 1'b0;
      wait_done(600, "repeat_done_timeout");
      foreach (dut_tog[i]) begin
        if (pass == 0) rep1.push_back(dut_tog[i] - rep_r);
        else           rep2.push_back(dut_tog[i] - rep_r);
      end
    end
    chk("repeat_len", rep2.size(), rep1.size());
    for (int i = 0; i < rep1.size() && i < rep2.size(); i++) chk("repeat_edge", rep2[i], rep1[i]);

    // Random traffic, including commands while busy and no-ops.
    for (int i = 0; i < 4000; i++) begin
      a_valid = ($urandom_range(0, 7) == 0);
      a_level = 1'($urandom_range(0, 1));
      tick();
    end
    a_valid = 1'b0;
    wait_done(600, "final_drain_timeout");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
